// File: rtl/div32x32_seq.sv
// ----------------------------------------------------------------------------
// div32x32_seq
//
// Sequential unsigned integer divider (restoring, radix-2). One quotient bit
// is produced per clock, so a division occupies the block for WIDTH cycles.
// Shares the start/busy handshake of the companion 32x32 multiplier so the
// same host FSM can drive either block.
//
// Handshake (start/busy):
//   A request is accepted on a rising clk edge where state==IDLE (busy==0)
//   and start==1; a and b are captured on that edge only. busy rises right
//   after the accepting edge and falls on the completion edge. quotient and
//   remainder are valid from the first cycle with busy==0 and hold until the
//   next completion or reset. start while busy==1 is ignored, not queued.
//
// Optional feature (macro DIV32_DBZ_EN):
//   When defined, a dbz port is added and a request with b==0 completes after
//   a single busy cycle with quotient=all ones, remainder=a, dbz=1. dbz clears
//   on the next accepted request. When undefined, b==0 runs the normal
//   WIDTH-cycle path, which yields the same quotient/remainder.
//
// Ports:
//   clk        in   1      clock, all state updates on posedge
//   reset      in   1      synchronous, active-high; aborts any operation
//   start      in   1      request, sampled only while busy==0
//   a          in   WIDTH  dividend (unsigned)
//   b          in   WIDTH  divisor (unsigned)
//   busy       out  1      division in progress
//   quotient   out  WIDTH  floor(a/b) of the last completed operation
//   remainder  out  WIDTH  a - b*quotient of the last completed operation
//   dbz        out  1      divide-by-zero flag (DIV32_DBZ_EN only)
//
// Debug visibility: the FSM state is held in state_q (type state_t) and the
// iteration counter in cnt_q; both are plain named signals for binding.
// ----------------------------------------------------------------------------
module div32x32_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
`ifdef DIV32_DBZ_EN
  ,
  output logic             dbz
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_t;

  state_t state_q;
  state_t state_d;

  // Dividend shift register doubles as the quotient accumulator: each
  // iteration the dividend MSB moves into the partial remainder and the new
  // quotient bit enters at the LSB. After WIDTH shifts it holds the quotient.
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH-1:0] rem_q;
  logic [CW-1:0]    cnt_q;

  logic             accept;
  logic             last_iter;

  // One restoring step, evaluated in WIDTH+1 bits so the shifted partial
  // remainder can never overflow before the compare.
  logic [WIDTH:0]   r_shift;
  logic [WIDTH:0]   r_diff;
  logic             q_bit;
  logic [WIDTH-1:0] r_next;
  logic [WIDTH-1:0] q_next;

`ifdef DIV32_DBZ_EN
  // Set on accepting a zero divisor; the single CALC cycle that follows
  // publishes the defined divide-by-zero result instead of iterating.
  logic dbz_pend_q;
  logic dbz_q;
  assign dbz = dbz_q;
`endif

  assign accept    = (state_q == IDLE) && start;
  assign last_iter = (cnt_q == '0);
  assign busy      = (state_q == CALC);

  // --------------------------------------------------------------------------
  // Datapath combinational step
  // --------------------------------------------------------------------------
  always_comb begin
    r_shift = {rem_q, dvd_q[WIDTH-1]};
    r_diff  = r_shift - {1'b0, dvs_q};
    q_bit   = (r_shift >= {1'b0, dvs_q});
    r_next  = q_bit ? r_diff[WIDTH-1:0] : r_shift[WIDTH-1:0];
    q_next  = {dvd_q[WIDTH-2:0], q_bit};
  end

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CALC;
        end
      end
      CALC: begin
        // The zero-divisor shortcut loads cnt_q with 0, so last_iter also
        // ends that one-cycle pass.
        if (last_iter) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      dvd_q      <= '0;
      dvs_q      <= '0;
      rem_q      <= '0;
      cnt_q      <= '0;
      quotient   <= '0;
      remainder  <= '0;
`ifdef DIV32_DBZ_EN
      dbz_pend_q <= 1'b0;
      dbz_q      <= 1'b0;
`endif
    end else if (accept) begin
      dvd_q <= a;
      dvs_q <= b;
      rem_q <= '0;
`ifdef DIV32_DBZ_EN
      dbz_q <= 1'b0;
      if (b == '0) begin
        dbz_pend_q <= 1'b1;
        cnt_q      <= '0;
      end else begin
        dbz_pend_q <= 1'b0;
        cnt_q      <= CNT_LAST;
      end
`else
      cnt_q <= CNT_LAST;
`endif
    end else if (state_q == CALC) begin
`ifdef DIV32_DBZ_EN
      if (dbz_pend_q) begin
        quotient   <= '1;
        remainder  <= dvd_q;
        dbz_q      <= 1'b1;
        dbz_pend_q <= 1'b0;
      end else begin
`endif
        dvd_q <= q_next;
        rem_q <= r_next;
        cnt_q <= cnt_q - 1'b1;
        // Result registers move only on the completion edge, so the outputs
        // never expose a partially built quotient.
        if (last_iter) begin
          quotient  <= q_next;
          remainder <= r_next;
        end
`ifdef DIV32_DBZ_EN
      end
`endif
    end
  end

endmodule

// File: tb/tb_div32x32_seq.sv
// ----------------------------------------------------------------------------
// tb_div32x32_seq
//
// Directed bench for div32x32_seq. Expected quotient, remainder and busy
// length are computed from the operands when a request is driven, pushed to
// scoreboard queues, and popped when the DUT drops busy. Inputs change and
// outputs are sampled on the falling clock edge.
// ----------------------------------------------------------------------------
module tb_div32x32_seq;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
`ifdef DIV32_DBZ_EN
  logic         dbz;
`endif

  int total = 0;
  int bad   = 0;

  logic [W-1:0] exp_quo[$];
  logic [W-1:0] exp_rem[$];
  logic [W-1:0] exp_cyc[$];

  // --------------------------------------------------------------------------
  // Clock
  // --------------------------------------------------------------------------
  always #5 clk = ~clk;

  div32x32_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .quotient  (quotient),
    .remainder (remainder)
`ifdef DIV32_DBZ_EN
    ,
    .dbz       (dbz)
`endif
  );

  // --------------------------------------------------------------------------
  // Comparison helper
  // --------------------------------------------------------------------------
  task automatic check(input string tag, input logic [W-1:0] got,
                       input logic [W-1:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // --------------------------------------------------------------------------
  // Driver: present a request for one accepting edge and record expectations.
  // Returns at the falling edge after the accepting edge (first busy cycle).
  // hold keeps start asserted afterwards.
  // --------------------------------------------------------------------------
  task automatic start_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                          input bit hold);
    @(negedge clk);
    a     = av;
    b     = bv;
    start = 1'b1;
    exp_quo.push_back((bv == '0) ? {W{1'b1}} : av / bv);
    exp_rem.push_back((bv == '0) ? av : av % bv);
`ifdef DIV32_DBZ_EN
    exp_cyc.push_back((bv == '0) ? W'(1) : W'(W));
`else
    exp_cyc.push_back(W'(W));
`endif
    @(negedge clk);
    if (!hold) start = 1'b0;
  endtask

  // --------------------------------------------------------------------------
  // Monitor: count remaining busy cycles (bounded), then compare with the
  // scoreboard head. 'already' is the number of busy cycles the caller has
  // stepped past since start_op returned.
  // --------------------------------------------------------------------------
  task automatic wait_done(input string tag, input int already);
    int           cyc;
    logic [W-1:0] eq;
    logic [W-1:0] er;
    logic [W-1:0] ec;
    cyc = already;
    while (busy === 1'b1 && cyc < 200) begin
      cyc++;
      @(negedge clk);
    end
    total++;
    assert (exp_quo.size() != 0) else begin
      bad++;
      $error("FAIL %s_sb: got=empty expected=entry", tag);
    end
    if (exp_quo.size() == 0) return;
    eq = exp_quo.pop_front();
    er = exp_rem.pop_front();
    ec = exp_cyc.pop_front();
    check({tag, "_cycles"}, W'(cyc), ec);
    check({tag, "_quo"}, quotient, eq);
    check({tag, "_rem"}, remainder, er);
`ifdef DIV32_DBZ_EN
    check({tag, "_dbz"}, W'(dbz), (ec == W'(1)) ? W'(1) : W'(0));
`endif
  endtask

  // --------------------------------------------------------------------------
  // Directed sequence
  // --------------------------------------------------------------------------
  initial begin
    reset = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", W'(busy), W'(0));
    check("rst_quo", quotient, W'(0));
    check("rst_rem", remainder, W'(0));
`ifdef DIV32_DBZ_EN
    check("rst_dbz", W'(dbz), W'(0));
`endif
    reset = 1'b0;
    @(negedge clk);

    // a < b
    start_op(32'd212533061, 32'd342824687, 1'b0);
    wait_done("lt", 0);
    check("lt_quo_const", quotient, W'(0));
    check("lt_rem_const", remainder, 32'd212533061);

    // ordinary divisions
    start_op(32'd342824687, 32'd212533061, 1'b0);
    wait_done("gt", 0);
    check("gt_rem_const", remainder, 32'd130291626);
    start_op(32'd100, 32'd7, 1'b0);
    wait_done("small", 0);
    check("small_quo_const", quotient, 32'd14);

    // boundaries
    start_op(32'hFFFF_FFFF, 32'd1, 1'b0);
    wait_done("max_by_1", 0);
    start_op(32'hFFFF_0000, 32'h0001_0000, 1'b0);
    wait_done("hi_half", 0);
    start_op(32'd0, 32'd9, 1'b0);
    wait_done("zero_a", 0);
    start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    wait_done("equal", 0);
    start_op(32'h8000_0001, 32'h8000_0000, 1'b0);
    wait_done("msb_div", 0);

    // random operands
    for (int i = 0; i < 4; i++) begin
      start_op($urandom, $urandom_range(1, 65535), 1'b0);
      wait_done("rand", 0);
    end

    // start pulsed during busy cycle 5 with other operands is ignored
    start_op(32'd1000, 32'd33, 1'b0);
    repeat (4) @(negedge clk);
    a     = 32'd77;
    b     = 32'd5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("ignore", 5);
    check("ignore_idle", W'(busy), W'(0));

    // reset during busy cycle 10 aborts the operation
    start_op(32'd123456789, 32'd1234, 1'b0);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", W'(busy), W'(0));
    check("abort_quo", quotient, W'(0));
    check("abort_rem", remainder, W'(0));
    void'(exp_quo.pop_front());
    void'(exp_rem.pop_front());
    void'(exp_cyc.pop_front());
    start_op(32'd123456789, 32'd1234, 1'b0);
    wait_done("after_abort", 0);

    // start held high: next request accepted the cycle after completion
    start_op(32'd100, 32'd7, 1'b1);
    wait_done("held1", 0);
    a = 32'd342824687;
    b = 32'd212533061;
    exp_quo.push_back(32'd1);
    exp_rem.push_back(32'd130291626);
    exp_cyc.push_back(W'(W));
    @(negedge clk);
    start = 1'b0;
    check("held_restart", W'(busy), W'(1));
    wait_done("held2", 0);

    // divide by zero
    start_op(32'd55, 32'd0, 1'b0);
    wait_done("dbz", 0);
    check("dbz_quo_const", quotient, 32'hFFFF_FFFF);
    check("dbz_rem_const", remainder, 32'd55);
    start_op(32'd100, 32'd7, 1'b0);
`ifdef DIV32_DBZ_EN
    check("dbz_clr", W'(dbz), W'(0));
`endif
    wait_done("post_dbz", 0);

    check("sb_drained", W'(exp_quo.size()), W'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
